misao_mem_arbiter: RTL and testbench

//  Shares the single 8-bit MISA-O memory port between instruction fetch (read-only)
//  and XMEM data access (load/store). Registers all memory-side outputs, tracks the
//  one-cycle read latency of the external memory and returns read data to the owner.

---
 rtl/misao_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_misao_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/misao_mem_arbiter.sv
// rtl/misao_mem_arbiter.sv - arbitrates the single MISA-O memory port between fetch and XMEM data access
// Optional fetch starvation guard: define MISAO_ARB_STARVE_GUARD_EN.
module misao_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_wdone,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state, state_next;
  logic              owner_dm;
  logic              lat_store;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              force_if;
  logic              grant;
  logic              grant_store;

`ifdef MISAO_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;

  assign force_if = (streak == SW'(MAX_STREAK)) && if_req && dm_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      streak <= '0;
    else if (if_gnt)
      streak <= '0;
    else if (dm_gnt && if_req)
      streak <= streak + 1'b1;
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant) state_next = S_ISSUE;
      S_ISSUE: state_next = lat_store ? S_IDLE : S_WAIT;
      S_WAIT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Grants are combinational and only offered from IDLE; data wins unless the guard forces fetch.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (force_if)
        if_gnt = 1'b1;
      else if (dm_req)
        dm_gnt = 1'b1;
      else
        if_gnt = if_req;
    end
    if_rvalid = (state == S_WAIT) && !owner_dm;
    dm_rvalid = (state == S_WAIT) && owner_dm;
    if_rdata  = if_rvalid ? mem_data_in : if_rdata_q;
    dm_rdata  = dm_rvalid ? mem_data_in : dm_rdata_q;
  end

  assign grant       = if_gnt | dm_gnt;
  assign grant_store = dm_gnt & dm_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm         <= 1'b0;
      lat_store        <= 1'b0;
      mem_enable_read  <= 1'b0;
      mem_enable_write <= 1'b0;
      mem_rw           <= 1'b0;
      dm_wdone         <= 1'b0;
      mem_addr         <= '0;
      mem_data_out     <= '0;
      if_rdata_q       <= '0;
      dm_rdata_q       <= '0;
    end else begin
      mem_enable_read  <= grant & ~grant_store;
      mem_enable_write <= grant_store;
      mem_rw           <= grant_store;
      dm_wdone         <= grant_store;
      if (grant) begin
        owner_dm  <= dm_gnt;
        lat_store <= grant_store;
        mem_addr  <= dm_gnt ? dm_addr : if_addr;
      end
      if (grant_store)
        mem_data_out <= dm_wdata;
      if (if_rvalid)
        if_rdata_q <= mem_data_in;
      if (dm_rvalid)
        dm_rdata_q <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// tb/tb_misao_mem_arbiter.sv - directed self-checking bench for misao_mem_arbiter
module tb_misao_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [14:0] if_addr, dm_addr;
  logic [7:0]  dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_wdone;
  logic [7:0]  if_rdata, dm_rdata;
  logic        mem_enable_read, mem_enable_write, mem_rw;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_out, mem_data_in;

  logic [7:0]  mem [0:32767];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  misao_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_wdone(dm_wdone),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in)
  );

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_enable_write) mem[mem_addr] <= mem_data_out;
    if (mem_enable_read)  mem_data_in <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n_grants;
    int  n_dm;
    int  if_while_dm;
    logic [4:0] seq;

    rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem[15'h0002] = 8'h54;
    mem[15'h0010] = 8'h77;
    mem[15'h0020] = 8'hA1;
    mem[15'h0030] = 8'hB2;
    mem[15'h0040] = 8'h11;

    // Reset with random request activity
    for (int i = 0; i < 5; i++) begin
      if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
      if_addr = 15'($urandom); dm_addr = 15'($urandom);
      step();
      check("rst_quiet", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, dm_wdone,
                          mem_enable_read, mem_enable_write}, 32'h0);
    end
    check("rst_addr", mem_addr, 32'h0);
    check("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
    if_req = 0; dm_req = 0; dm_we = 0;
    rst = 1'b0;
    step();

    // Fetch from 0x0002
    if_req = 1; if_addr = 15'h0002;
    #1;
    check("fetch_gnt", {if_gnt, dm_gnt}, 32'h2);
    step();
    if_req = 0;
    check("fetch_issue_strobes", {mem_enable_read, mem_enable_write, mem_rw}, 32'h4);
    check("fetch_issue_addr", mem_addr, 32'h0002);
    check("fetch_issue_nognt", {if_gnt, if_rvalid}, 32'h0);
    step();
    check("fetch_rvalid", {if_rvalid, dm_rvalid}, 32'h2);
    check("fetch_rdata", if_rdata, 32'h54);
    check("fetch_wait_strobes", {mem_enable_read, mem_enable_write}, 32'h0);
    step();
    check("fetch_done", if_rvalid, 32'h0);
    check("fetch_rdata_hold", if_rdata, 32'h54);

    // Store 0x05 to 0x0000
    dm_req = 1; dm_we = 1; dm_addr = 15'h0000; dm_wdata = 8'h05;
    #1;
    check("store_gnt", {if_gnt, dm_gnt}, 32'h1);
    step();
    dm_req = 0;
    check("store_issue", {mem_enable_read, mem_enable_write, mem_rw, dm_wdone}, 32'h7);
    check("store_data", {mem_addr, mem_data_out}, {17'h0, 15'h0000, 8'h05});
    step();
    check("store_wdone_pulse", {dm_wdone, mem_enable_write}, 32'h0);

    // Load back from 0x0000
    dm_req = 1; dm_we = 0; dm_addr = 15'h0000;
    #1;
    check("load_gnt", dm_gnt, 32'h1);
    step();
    dm_req = 0;
    check("load_issue", {mem_enable_read, mem_enable_write, mem_rw, dm_wdone}, 32'h8);
    step();
    check("load_rvalid", {if_rvalid, dm_rvalid}, 32'h1);
    check("load_rdata", dm_rdata, 32'h05);
    step();
    check("load_rdata_hold", {dm_rvalid, dm_rdata}, 32'h05);

    // Contention: data first, then fetch
    if_req = 1; if_addr = 15'h0020;
    dm_req = 1; dm_we = 0; dm_addr = 15'h0030;
    #1;
    check("cont_first_gnt", {if_gnt, dm_gnt}, 32'h1);
    step();
    dm_req = 0;
    check("cont_issue_nognt", {if_gnt, dm_gnt}, 32'h0);
    check("cont_issue_addr", mem_addr, 32'h0030);
    step();
    check("cont_dm_rvalid", {if_rvalid, dm_rvalid}, 32'h1);
    check("cont_dm_rdata", dm_rdata, 32'hB2);
    check("cont_wait_nognt", if_gnt, 32'h0);
    step();
    check("cont_if_gnt", {if_gnt, dm_gnt}, 32'h2);
    step();
    if_req = 0;
    check("cont_if_addr", mem_addr, 32'h0020);
    step();
    check("cont_if_rvalid", {if_rvalid, dm_rvalid}, 32'h2);
    check("cont_if_rdata", if_rdata, 32'hA1);
    check("cont_dm_rdata_hold", dm_rdata, 32'hB2);
    step();

    // Reset while waiting on a fetch from 0x0010
    if_req = 1; if_addr = 15'h0010;
    #1;
    check("rstw_gnt", if_gnt, 32'h1);
    step();
    if_req = 0;
    step();
    rst = 1'b1;
    #1;
    check("rstw_no_rvalid", if_rvalid, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstw_post_rvalid", {if_rvalid, mem_enable_read}, 32'h0);
    end
    check("rstw_rdata_cleared", if_rdata, 32'h0);
    // Request raised and dropped before any edge: grant visible, nothing issued
    if_req = 1; if_addr = 15'h0002;
    #1;
    check("rstw_idle_gnt", if_gnt, 32'h1);
    if_req = 0;
    step();
    check("drop_no_issue", {mem_enable_read, mem_enable_write}, 32'h0);

    // Both requesters held high
    if_req = 1; if_addr = 15'h0002;
    dm_req = 1; dm_we = 0; dm_addr = 15'h0040;
    n_grants = 0; n_dm = 0; if_while_dm = 0; seq = '0;
    for (int c = 0; c < 40 && n_grants < 5; c++) begin
      #1;
      check("guard_one_hot_gnt", 32'(if_gnt & dm_gnt), 32'h0);
      if (if_gnt || dm_gnt) begin
        seq[n_grants] = if_gnt;
        if (dm_gnt) n_dm++;
        if (if_gnt && dm_req) if_while_dm++;
        n_grants++;
      end
      check("guard_rvalid_excl", 32'(if_rvalid & dm_rvalid), 32'h0);
      @(posedge clk);
    end
    check("guard_grant_count", n_grants, 32'd5);
`ifdef MISAO_ARB_STARVE_GUARD_EN
    check("guard_sequence", seq, 32'h10);
    check("guard_dm_count", n_dm, 32'd4);
`else
    check("noguard_sequence", seq, 32'h00);
    check("noguard_if_while_dm", if_while_dm, 32'd0);
`endif
    if_req = 0; dm_req = 0;
    repeat (4) step();
    check("final_idle", {mem_enable_read, mem_enable_write, if_rvalid, dm_rvalid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
